cdc_handshake_rx: RTL and testbench
===================================

Name: cdc_handshake_rx

Overview:
- Destination-domain end of a toggle-based req/ack handshake used to move a multi-bit word between asynchronous clock domains.
- Source side: holds `data_in` stable, then toggles `req_tgl`.
- This block: synchronizes `req_tgl` into `out_clk`, captures `data_in`, and presents it with valid/ready to the local consumer.
- Returns `ack_tgl` only once the word is consumed, giving end-to-end backpressure to the source.
- Single-clock block; the source-domain sender is a separate block.

Parameters:
- DATA_WIDTH, 32, width of transferred word.
- SYNC_STAGES, 2, flops in `req_tgl` synchronizer chain; legal range 2..4.

Ports:
- out_clk  input  1  destination-domain clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion assumed synchronous to out_clk.
- req_tgl  input  1  request toggle from source domain; asynchronous to out_clk.
- data_in  input  DATA_WIDTH  source word; asynchronous, guaranteed stable from before req_tgl toggles until ack_tgl toggle is seen by source.
- out_ready  input  1  consumer can accept data_out this cycle.
- data_out  output  DATA_WIDTH  captured word.
- data_valid  output  1  data_out holds an unconsumed word.
- ack_tgl  output  1  acknowledge toggle back to source domain; driven directly from a flop.
- proto_err  output  1  sticky: source toggled req_tgl again before ack.

Behaviour:
- Reset (rst=0, async):
  - sync chain, req_seen, req_prev, data_out, data_valid, ack_tgl, proto_err all 0.
  - FSM enters IDLE.
- Synchronizer: `sync[0] <= req_tgl; sync[i] <= sync[i-1]`. Only `sync[SYNC_STAGES-1]` (req_s) is used by logic. Nothing else samples req_tgl.
- New request is `req_s != req_seen`.
- FSM states: IDLE, HOLD.
  - IDLE, no new request: hold all outputs.
  - IDLE, new request: on that edge `data_out <= data_in` (full width, no masking), `data_valid <= 1`, go HOLD. req_seen unchanged.
  - HOLD, `out_ready=0`: data_out and data_valid held stable. Consumer may not see data change while valid.
  - HOLD, `out_ready=1`: on that edge `data_valid <= 0`, `ack_tgl <= ~ack_tgl`, `req_seen <= req_s`, go IDLE.
- Latency: req_tgl toggle sampled at edge k → data_valid high after edge k+SYNC_STAGES. Ack toggles on the edge where data_valid & out_ready are both high.
- Throughput: at most one word per full round trip. The next capture cannot occur before the source sees ack and toggles again. There is no bypass from IDLE to output.
- out_ready is ignored in IDLE; data_valid is never asserted combinationally.
- Protocol error:
  - `req_prev <= req_s` every cycle.
  - In HOLD, `req_s != req_prev` → `proto_err <= 1`, sticky until reset.
  - The offending toggle is not captured. req_seen is still updated to the current req_s on consume, so the extra toggle is absorbed.
- Simultaneous consume and error on the same edge: both actions take effect.
- Reset mid-transfer: word dropped, ack not sent. The system must reset the source side in the same reset window.
- Reset with req_tgl=1: req_s rises after SYNC_STAGES edges and is treated as a new request. The source must reset its toggle to 0.
- data_in is sampled only on the capture edge. Metastability safety relies on the source stability guarantee; data_in bits are never synchronized.

Test Plan:
- Single transfer, DATA_WIDTH=32, SYNC_STAGES=2: data_in=0xDEADBEEF, toggle req_tgl 0→1, out_ready=1 → data_valid high exactly 2 edges after req_tgl first sampled, data_out=0xDEADBEEF, valid for 1 cycle, ack_tgl 0→1 on that edge.
- Backpressure: out_ready=0 for 10 cycles after valid → data_out/data_valid stable 10 cycles, ack_tgl unchanged. Then out_ready=1 → ack toggles once, data_valid=0 next cycle.
- Back-to-back: 3 words 0x1, 0x2, 0x3 via a model source that waits for ack each time → data_out sequence 0x1, 0x2, 0x3 with no duplicates or drops; ack_tgl ends at 1 (3 toggles); proto_err=0.
- Protocol violation: toggle req_tgl twice while in HOLD with out_ready=0 → proto_err=1 and stays 1. After consume, no phantom second word is produced.
- Async reset mid-HOLD: drive rst=0 between clock edges → data_valid, data_out, ack_tgl, proto_err go 0 immediately. After release with req_tgl=0, no spurious valid.
- SYNC_STAGES=3 with random out_clk/source phase: data_valid latency equals 3 edges after sampling, and at least 200 transfers complete with data integrity.

Source files
------------

// File: rtl/cdc_handshake_rx.sv
// Destination end of a toggle req/ack handshake: synchronises req_tgl, captures the
// stable source word, presents it with valid/ready and returns ack once consumed.
module cdc_handshake_rx #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  out_clk,
  input  logic                  rst,
  input  logic                  req_tgl,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ack_tgl,
  output logic                  proto_err
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    w_req_s;
  logic                    r_req_seen;
  logic                    w_req_seen_nxt;
  logic                    r_req_prev;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   w_data_nxt;
  logic                    r_valid;
  logic                    w_valid_nxt;
  logic                    r_ack;
  logic                    w_ack_nxt;
  logic                    r_err;
  logic                    w_err_nxt;
  logic                    w_new_req;
  logic                    w_req_moved;

  // Only the last stage of the chain is ever looked at by the logic below.
  assign w_req_s     = r_sync[SYNC_STAGES-1];
  assign w_new_req   = (w_req_s != r_req_seen);
  assign w_req_moved = (w_req_s != r_req_prev);

  always_ff @(posedge out_clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_req_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], req_tgl};
      r_req_prev <= w_req_s;
    end
  end

  always_ff @(posedge out_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_req_seen <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_seen <= w_req_seen_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_seen_nxt = r_req_seen;
    w_data_nxt     = r_data;
    w_valid_nxt    = r_valid;
    w_ack_nxt      = r_ack;
    w_err_nxt      = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_new_req) begin
          w_data_nxt  = data_in;
          w_valid_nxt = 1'b1;
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        // A second toggle before ack is flagged but absorbed: req_seen jumps to req_s.
        if (w_req_moved) begin
          w_err_nxt = 1'b1;
        end
        if (out_ready) begin
          w_valid_nxt    = 1'b0;
          w_ack_nxt      = ~r_ack;
          w_req_seen_nxt = w_req_s;
          w_state_nxt    = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign ack_tgl    = r_ack;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: directed checks on a 2-stage instance and a randomised
// 200-word run on a 3-stage instance with an unrelated source phase.
module tb_cdc_handshake_rx;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned DW    = 32;
  localparam int unsigned SYNC3 = 3;
  localparam int unsigned NXFER = 200;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- instance with SYNC_STAGES=2 ----------------
  logic          clk2 = 1'b0;
  logic          rst2;
  logic          req2;
  logic [DW-1:0] din2;
  logic          ready2;
  logic [DW-1:0] dout2;
  logic          valid2;
  logic          ack2;
  logic          err2;
  logic [DW-1:0] q2[$];

  // ---------------- instance with SYNC_STAGES=3 ----------------
  logic          clk3 = 1'b0;
  logic          rst3;
  logic          req3;
  logic [DW-1:0] din3;
  logic          ready3;
  logic [DW-1:0] dout3;
  logic          valid3;
  logic          ack3;
  logic          err3;
  logic [DW-1:0] q3[$];
  int            edge3 = 0;
  int            mark3 = 0;
  logic          req3_last = 1'b0;
  logic          valid3_prev = 1'b0;
  int            pops3 = 0;
  logic          done3 = 1'b0;

  cdc_handshake_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) u_dut2 (
    .out_clk   (clk2),
    .rst       (rst2),
    .req_tgl   (req2),
    .data_in   (din2),
    .out_ready (ready2),
    .data_out  (dout2),
    .data_valid(valid2),
    .ack_tgl   (ack2),
    .proto_err (err2)
  );

  cdc_handshake_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC3)) u_dut3 (
    .out_clk   (clk3),
    .rst       (rst3),
    .req_tgl   (req3),
    .data_in   (din3),
    .out_ready (ready3),
    .data_out  (dout3),
    .data_valid(valid3),
    .ack_tgl   (ack3),
    .proto_err (err3)
  );

  always #5 clk2 = ~clk2;

  initial begin
    #3.7;
    forever #7.3 clk3 = ~clk3;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitors: a word is consumed on the edge after valid&ready is seen here.
  always @(negedge clk2) begin
    if (rst2 && valid2 && ready2) begin
      check_eq("sb2_avail", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) check_eq("sb2_data", 64'(dout2), 64'(q2.pop_front()));
    end
  end

  always @(posedge clk3) begin
    edge3++;
    if (req3 !== req3_last) begin
      mark3     = edge3;
      req3_last = req3;
    end
  end

  always @(negedge clk3) begin
    if (valid3 && !valid3_prev) check_eq("lat3", 64'(edge3 - mark3), 64'(SYNC3));
    valid3_prev = valid3;
    if (rst3 && valid3 && ready3) begin
      check_eq("sb3_avail", 64'(q3.size() != 0), 64'd1);
      if (q3.size() != 0) check_eq("sb3_data", 64'(dout3), 64'(q3.pop_front()));
      pops3++;
    end
  end

  task automatic drive2();
    @(posedge clk2);
    #2;
  endtask

  task automatic wait_valid2();
    int n = 0;
    @(negedge clk2);
    while (!valid2 && n < 20) begin
      @(negedge clk2);
      n++;
    end
    check_eq("valid2_seen", 64'(valid2), 64'd1);
  endtask

  task automatic send2(input logic [DW-1:0] d, input bit wait_ack);
    logic old;
    int   n;
    drive2();
    din2 = d;
    q2.push_back(d);
    req2 = ~req2;
    if (wait_ack) begin
      old = ack2;
      n   = 0;
      @(negedge clk2);
      while (ack2 == old && n < 30) begin
        @(negedge clk2);
        n++;
      end
      check_eq("ack2_seen", 64'(ack2 != old), 64'd1);
    end
  endtask

  task automatic run_dut2();
    // reset state
    @(negedge clk2);
    check_eq("rst_valid", 64'(valid2), 64'd0);
    check_eq("rst_data", 64'(dout2), 64'd0);
    check_eq("rst_ack", 64'(ack2), 64'd0);
    check_eq("rst_err", 64'(err2), 64'd0);
    drive2();
    rst2   = 1'b1;
    ready2 = 1'b1;
    repeat (3) @(negedge clk2);

    // single transfer with exact latency
    drive2();
    din2 = 32'hDEADBEEF;
    q2.push_back(32'hDEADBEEF);
    req2 = 1'b1;
    @(negedge clk2);
    @(negedge clk2);
    check_eq("lat_k", 64'(valid2), 64'd0);
    @(negedge clk2);
    check_eq("lat_k1", 64'(valid2), 64'd0);
    @(negedge clk2);
    check_eq("lat_k2_valid", 64'(valid2), 64'd1);
    check_eq("lat_k2_data", 64'(dout2), 64'hDEADBEEF);
    check_eq("lat_k2_ack", 64'(ack2), 64'd0);
    @(negedge clk2);
    check_eq("one_cycle_valid", 64'(valid2), 64'd0);
    check_eq("first_ack", 64'(ack2), 64'd1);

    // backpressure
    drive2();
    ready2 = 1'b0;
    send2(32'hA5A5A5A5, 1'b0);
    wait_valid2();
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_data", 64'(dout2), 64'hA5A5A5A5);
      check_eq("bp_valid", 64'(valid2), 64'd1);
      check_eq("bp_ack", 64'(ack2), 64'd1);
      @(negedge clk2);
    end
    drive2();
    ready2 = 1'b1;
    @(negedge clk2);
    @(negedge clk2);
    check_eq("bp_drop_valid", 64'(valid2), 64'd0);
    check_eq("bp_ack_toggle", 64'(ack2), 64'd0);

    // back-to-back words from a source that waits for ack
    send2(32'h1, 1'b1);
    send2(32'h2, 1'b1);
    send2(32'h3, 1'b1);
    repeat (3) @(negedge clk2);
    check_eq("b2b_ack", 64'(ack2), 64'd1);
    check_eq("b2b_err", 64'(err2), 64'd0);
    check_eq("b2b_sb_empty", 64'(q2.size()), 64'd0);

    // protocol violation: two extra toggles while held
    drive2();
    ready2 = 1'b0;
    send2(32'h77, 1'b0);
    wait_valid2();
    repeat (2) begin
      drive2();
      req2 = ~req2;
      repeat (4) @(negedge clk2);
    end
    check_eq("pv_err", 64'(err2), 64'd1);
    check_eq("pv_hold_data", 64'(dout2), 64'h77);
    check_eq("pv_hold_valid", 64'(valid2), 64'd1);
    drive2();
    ready2 = 1'b1;
    repeat (10) @(negedge clk2);
    check_eq("pv_no_phantom", 64'(valid2), 64'd0);
    check_eq("pv_err_sticky", 64'(err2), 64'd1);
    check_eq("pv_sb_empty", 64'(q2.size()), 64'd0);

    // asynchronous reset while holding a word
    drive2();
    ready2 = 1'b0;
    send2(32'h1234, 1'b0);
    wait_valid2();
    drive2();
    rst2 = 1'b0;
    #1;
    check_eq("ar_valid", 64'(valid2), 64'd0);
    check_eq("ar_data", 64'(dout2), 64'd0);
    check_eq("ar_ack", 64'(ack2), 64'd0);
    check_eq("ar_err", 64'(err2), 64'd0);
    q2.delete();
    req2 = 1'b0;
    din2 = '0;
    repeat (3) drive2();
    rst2   = 1'b1;
    ready2 = 1'b1;
    repeat (12) @(negedge clk2);
    check_eq("ar_no_spurious", 64'(valid2), 64'd0);
    check_eq("ar_ack_after", 64'(ack2), 64'd0);
  endtask

  task automatic run_dut3();
    logic old;
    int   n;
    #31;
    rst3 = 1'b1;
    for (int i = 0; i < int'(NXFER); i++) begin
      // negedge times never share a fractional part with posedges after the +0.25 offset
      @(negedge clk3);
      #($urandom_range(1, 30) * 1.0 + 0.25);
      din3 = $urandom;
      q3.push_back(din3);
      old  = ack3;
      req3 = ~req3;
      n    = 0;
      @(negedge clk3);
      while (ack3 == old && n < 200) begin
        @(negedge clk3);
        n++;
      end
      if (ack3 == old) begin
        check_eq("ack3_seen", 64'(ack3 != old), 64'd1);
        break;
      end
    end
    repeat (5) @(negedge clk3);
    done3 = 1'b1;
    check_eq("s3_count", 64'(pops3), 64'(NXFER));
    check_eq("s3_sb_empty", 64'(q3.size()), 64'd0);
    check_eq("s3_err", 64'(err3), 64'd0);
  endtask

  initial begin
    while (!done3) begin
      @(posedge clk3);
      #2;
      ready3 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst2 = 1'b1; req2 = 1'b0; din2 = '0; ready2 = 1'b0;
    rst3 = 1'b1; req3 = 1'b0; din3 = '0; ready3 = 1'b0;
    #1;
    rst2 = 1'b0;
    rst3 = 1'b0;
    fork
      run_dut2();
      run_dut3();
    join
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
